// File: rtl/bcd_conversion_arbiter.sv
// bcd_conversion_arbiter: round-robin shared double-dabble binary-to-BCD engine for two requesters
// Ports: CLOCK_50/reset (async, active-high); reqN_valid/reqN_data in, reqN_ready out (transfer = valid & ready);
//        bcd_hundreds/bcd_tens/bcd_ones + bcd_owner update as bcd_valid pulses; busy is high outside IDLE.
// Option: BCD_BLANK_LEADING_ZERO_EN turns leading zero digits into 4'hF (blank on the 7-segment decoder).
module bcd_conversion_arbiter #(
  parameter int WIDTH = 9
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic [3:0]       bcd_hundreds,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic             bcd_valid,
  output logic             bcd_owner,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] shreg;
  logic [11:0] acc, adj, acc_nx;
  logic [CW-1:0] count;
  logic owner, last_owner, grant0, grant1, accept, finish;
  logic [3:0] dig_h, dig_t;
`ifdef BCD_BLANK_LEADING_ZERO_EN
  localparam logic [3:0] LEAD_RST = 4'hF;
  assign dig_h = acc_nx[11:8] == 4'd0 ? 4'hF : acc_nx[11:8];
  assign dig_t = acc_nx[11:4] == 8'd0 ? 4'hF : acc_nx[7:4];
`else
  localparam logic [3:0] LEAD_RST = 4'h0;
  assign dig_h = acc_nx[11:8];
  assign dig_t = acc_nx[7:4];
`endif
  always_comb begin
    // last_owner==1 favours req0 on a tie, so service alternates under contention
    grant0 = req0_valid & (~req1_valid | last_owner);
    grant1 = req1_valid & (~req0_valid | ~last_owner);
    req0_ready = (state == IDLE) & grant0;
    req1_ready = (state == IDLE) & grant1;
    accept = req0_ready | req1_ready;
    finish = (state == SHIFT) && (count == CW'(1));
    bcd_valid = state == DONE;
    busy = state != IDLE;
    state_nx = state == IDLE ? (accept ? SHIFT : IDLE) : state == SHIFT ? (finish ? DONE : SHIFT) : IDLE;
    adj = acc;
    for (int i = 0; i < 3; i++)
      adj[4*i+:4] = acc[4*i+:4] >= 4'd5 ? acc[4*i+:4] + 4'd3 : acc[4*i+:4];
    acc_nx = (adj << 1) | 12'(shreg[WIDTH-1]);
  end
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      shreg <= '0;
      acc <= '0;
      count <= '0;
      owner <= 1'b0;
      last_owner <= 1'b1;
      bcd_hundreds <= LEAD_RST;
      bcd_tens <= LEAD_RST;
      bcd_ones <= 4'd0;
      bcd_owner <= 1'b0;
    end else begin
      if (accept) begin
        shreg <= req1_ready ? req1_data : req0_data;
        acc <= '0;
        count <= CW'(WIDTH);
        owner <= req1_ready;
        last_owner <= req1_ready;
      end else if (state == SHIFT) begin
        acc <= acc_nx;
        shreg <= shreg << 1;
        count <= count - CW'(1);
      end
      // results are captured from the final shift so they appear on DONE entry
      if (finish) begin
        bcd_hundreds <= dig_h;
        bcd_tens <= dig_t;
        bcd_ones <= acc_nx[3:0];
        bcd_owner <= owner;
      end
    end
endmodule

// File: tb/tb_bcd_conversion_arbiter.sv
// tb_bcd_conversion_arbiter: directed self-checking bench for bcd_conversion_arbiter
module tb_bcd_conversion_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0, req0_ready, req1_ready;
  logic [8:0] req0_data = '0, req1_data = '0;
  logic [3:0] bcd_hundreds, bcd_tens, bcd_ones;
  logic bcd_valid, bcd_owner, busy;
  int tests = 0, fails = 0;
  logic os0, os1;
  int inj_cycle = -1;
  logic [8:0] inj_data;
  int acc_c[$], res_c[$];
  logic acc_p[$];
  logic [12:0] res_w[$];
  typedef struct {logic p; logic [8:0] d; logic [3:0] h, t, o;} vec_t;
  vec_t vecs[8];

  bcd_conversion_arbiter #(.WIDTH(9)) dut (
    .CLOCK_50(clk), .reset(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .bcd_hundreds(bcd_hundreds), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
    .bcd_valid(bcd_valid), .bcd_owner(bcd_owner), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] blank(input logic [3:0] h, t, o);
`ifdef BCD_BLANK_LEADING_ZERO_EN
    return {h == 4'd0 ? 4'hF : h, (h == 4'd0 && t == 4'd0) ? 4'hF : t, o};
`else
    return {h, t, o};
`endif
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic check_reset();
    chk("rst_digits", {bcd_hundreds, bcd_tens, bcd_ones}, blank(4'd0, 4'd0, 4'd0));
    chk("rst_valid", bcd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", bcd_owner, 0);
    chk("rst_readys", {req0_ready, req1_ready}, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_result(input logic p, input logic [11:0] e);
    int c = 1;
    while (!bcd_valid && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    chk("latency", c, 10);
    chk("digits", {bcd_hundreds, bcd_tens, bcd_ones}, e);
    chk("owner", bcd_owner, p);
    @(posedge clk); #1;
    chk("valid_pulse", bcd_valid, 0);
    chk("busy_idle", busy, 0);
    chk("hold", {bcd_hundreds, bcd_tens, bcd_ones}, e);
  endtask

  task automatic convert(input logic p, input logic [8:0] d, input logic [11:0] e);
    if (p) begin req1_valid = 1'b1; req1_data = d; end
    else begin req0_valid = 1'b1; req0_data = d; end
    #1;
    chk("ready_on", p ? req1_ready : req0_ready, 1);
    chk("other_ready_off", p ? req0_ready : req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data = ~d;
    req1_data = ~d;
    #1;
    chk("ready_pulse", {req0_ready, req1_ready}, 0);
    chk("busy", busy, 1);
    wait_result(p, e);
  endtask

  task automatic monitor(input int n);
    int both = 0;
    logic a0, a1;
    acc_c.delete(); acc_p.delete(); res_c.delete(); res_w.delete();
    for (int c = 0; c < n; c++) begin
      if (c == inj_cycle) begin req0_valid = 1'b1; req0_data = inj_data; end
      #1;
      a0 = req0_ready;
      a1 = req1_ready;
      if (a0 && a1) both++;
      if (a0) begin acc_c.push_back(c); acc_p.push_back(1'b0); end
      if (a1) begin acc_c.push_back(c); acc_p.push_back(1'b1); end
      if (bcd_valid) begin res_c.push_back(c); res_w.push_back({bcd_owner, bcd_hundreds, bcd_tens, bcd_ones}); end
      @(posedge clk); #1;
      if (a0 && os0) req0_valid = 1'b0;
      if (a1 && os1) req1_valid = 1'b0;
    end
    chk("one_ready_max", both, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 9'd511, 4'd5, 4'd1, 4'd1};
    vecs[1] = '{1'b1, 9'd0,   4'd0, 4'd0, 4'd0};
    vecs[2] = '{1'b0, 9'd7,   4'd0, 4'd0, 4'd7};
    vecs[3] = '{1'b1, 9'd40,  4'd0, 4'd4, 4'd0};
    vecs[4] = '{1'b0, 9'd305, 4'd3, 4'd0, 4'd5};
    vecs[5] = '{1'b1, 9'd255, 4'd2, 4'd5, 4'd5};
    vecs[6] = '{1'b0, 9'd100, 4'd1, 4'd0, 4'd0};
    vecs[7] = '{1'b1, 9'd99,  4'd0, 4'd9, 4'd9};
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    rst = 1'b0;
    for (int i = 0; i < 8; i++)
      convert(vecs[i].p, vecs[i].d, blank(vecs[i].h, vecs[i].t, vecs[i].o));
    rst = 1'b1;
    #1;
    check_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    // req1 holds valid with 0; req0 asks for 7 in the middle of req1's conversion
    do_reset();
    req1_valid = 1'b1; req1_data = 9'd0;
    os0 = 1'b1; os1 = 1'b0; inj_cycle = 3; inj_data = 9'd7;
    monitor(33);
    req1_valid = 1'b0; inj_cycle = -1;
    chk("fair_accepts", acc_p.size(), 3);
    if (acc_p.size() == 3) chk("fair_order", {acc_p[0], acc_p[1], acc_p[2]}, 3'b101);
    chk("fair_results", res_w.size(), 3);
    if (res_w.size() == 3) begin
      chk("fair_r0", res_w[0], {1'b1, blank(4'd0, 4'd0, 4'd0)});
      chk("fair_r1", res_w[1], {1'b0, blank(4'd0, 4'd0, 4'd7)});
      chk("fair_r2", res_w[2], {1'b1, blank(4'd0, 4'd0, 4'd0)});
    end
    // both requesters held together from reset: req0 first, req1 eleven cycles later
    do_reset();
    req0_valid = 1'b1; req0_data = 9'd123;
    req1_valid = 1'b1; req1_data = 9'd45;
    os0 = 1'b1; os1 = 1'b1;
    monitor(23);
    chk("rr_accepts", acc_p.size(), 2);
    chk("rr_results", res_w.size(), 2);
    if (acc_p.size() == 2 && res_w.size() == 2) begin
      chk("rr_order", {acc_p[0], acc_p[1]}, 2'b01);
      chk("rr_spacing", acc_c[1] - acc_c[0], 11);
      chk("rr_latency", res_c[0] - acc_c[0], 10);
      chk("rr_r0", res_w[0], {1'b0, blank(4'd1, 4'd2, 4'd3)});
      chk("rr_r1", res_w[1], {1'b1, blank(4'd0, 4'd4, 4'd5)});
    end
    // reset in SHIFT cycle 4 with valid still held, then re-acceptance after release
    req0_valid = 1'b1; req0_data = 9'd300;
    #1;
    chk("abort_ready", req0_ready, 1);
    @(posedge clk); #1;
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_digits", {bcd_hundreds, bcd_tens, bcd_ones}, blank(4'd0, 4'd0, 4'd0));
    chk("abort_owner", bcd_owner, 0);
    chk("abort_valid", bcd_valid, 0);
    chk("abort_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("reaccept_ready", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_result(1'b0, blank(4'd3, 4'd0, 4'd0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
